// File: rtl/gcbp_pkg.sv
// Shared GCBP definitions: frame FSM encoding and BRAM geometry for the sub-image store.
package gcbp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } gcbp_frame_state_e;

  localparam int GCBP_BRAM_WORD_W    = 128;
  localparam int GCBP_BRAM_DEPTH     = 512;
  localparam int GCBP_BRAM_ADDR_W    = $clog2(GCBP_BRAM_DEPTH);
  localparam int GCBP_DEFAULT_STRIDE = 128;

  function automatic int gcbp_slot_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gcbp_frame_ring_ctrl_if.sv
// Encoder/correlator-facing signal bundle of the frame ring controller.
interface gcbp_frame_ring_ctrl_if #(
  parameter int C_SLOT_WIDTH = 2,
  parameter int C_ADDR_WIDTH = 9,
  parameter int C_CNT_WIDTH  = 7
);
  logic                    i_valid_subimage_line;
  logic                    i_new_line;
  logic                    i_new_frame;
  logic                    i_corr_busy;
  logic [C_SLOT_WIDTH-1:0] o_next_slot;
  logic [C_SLOT_WIDTH-1:0] o_curr_slot;
  logic [C_SLOT_WIDTH-1:0] o_prev_slot;
  logic [C_ADDR_WIDTH-1:0] o_write_addr;
  logic                    o_write_en;
  logic [C_CNT_WIDTH-1:0]  o_line_cnt;
  logic [1:0]              o_frames_valid;
  logic                    o_frame_commit;
  logic                    o_frame_drop;

  modport master (
    output i_valid_subimage_line, i_new_line, i_new_frame, i_corr_busy,
    input  o_next_slot, o_curr_slot, o_prev_slot, o_write_addr, o_write_en,
           o_line_cnt, o_frames_valid, o_frame_commit, o_frame_drop
  );

  modport slave (
    input  i_valid_subimage_line, i_new_line, i_new_frame, i_corr_busy,
    output o_next_slot, o_curr_slot, o_prev_slot, o_write_addr, o_write_en,
           o_line_cnt, o_frames_valid, o_frame_commit, o_frame_drop
  );
endinterface

// File: rtl/gcbp_mod_ring_ptr.sv
// Mod-N slot pointer; exposes the write slot and the two slots committed before it.
module gcbp_mod_ring_ptr #(
  parameter int C_NUM_SLOTS  = 3,
  parameter int C_SLOT_WIDTH = 2
) (
  input  logic                    i_clk,
  input  logic                    i_resetn,
  input  logic                    i_inc,
  output logic [C_SLOT_WIDTH-1:0] o_next,
  output logic [C_SLOT_WIDTH-1:0] o_curr,
  output logic [C_SLOT_WIDTH-1:0] o_prev
);
  localparam logic [C_SLOT_WIDTH-1:0] LAST_SLOT   = C_SLOT_WIDTH'(C_NUM_SLOTS - 1);
  localparam logic [C_SLOT_WIDTH-1:0] SECOND_LAST = C_SLOT_WIDTH'(C_NUM_SLOTS - 2);

  logic [C_SLOT_WIDTH-1:0] w_ptr_q, w_ptr_d;

  always_comb begin
    w_ptr_d = w_ptr_q;
    if (i_inc) begin
      w_ptr_d = (w_ptr_q == LAST_SLOT) ? '0 : w_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      w_ptr_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
    end
  end

  // Explicit wrap cases so non-power-of-2 slot counts stay correct.
  assign o_next = w_ptr_q;
  assign o_curr = (w_ptr_q == '0) ? LAST_SLOT : w_ptr_q - 1'b1;
  assign o_prev = (w_ptr_q == '0)                  ? SECOND_LAST :
                  (w_ptr_q == C_SLOT_WIDTH'(1))    ? LAST_SLOT   :
                                                     w_ptr_q - C_SLOT_WIDTH'(2);
endmodule

// File: rtl/gcbp_frame_ring_ctrl.sv
// GCBP sub-image ring controller: counts lines into the write slot and rotates slots on complete frames.
module gcbp_frame_ring_ctrl
  import gcbp_pkg::*;
#(
  parameter int C_NUM_SLOTS          = 3,
  parameter int C_LINES_PER_SUBIMAGE = 64,
  parameter int C_SLOT_STRIDE        = GCBP_DEFAULT_STRIDE,
  parameter int C_ADDR_WIDTH         = GCBP_BRAM_ADDR_W
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  gcbp_frame_ring_ctrl_if.slave bus
);
  localparam int C_SLOT_WIDTH   = gcbp_slot_width(C_NUM_SLOTS);
  localparam int C_CNT_WIDTH    = $clog2(C_LINES_PER_SUBIMAGE + 1);
  localparam int C_STRIDE_SHIFT = $clog2(C_SLOT_STRIDE);
  localparam logic [C_CNT_WIDTH-1:0] LINES_FULL = C_CNT_WIDTH'(C_LINES_PER_SUBIMAGE);

  gcbp_frame_state_e       state_q, state_d;
  logic [C_CNT_WIDTH-1:0]  line_cnt_q, line_cnt_d;
  logic [1:0]              frames_valid_q, frames_valid_d;
  logic                    commit_q, commit_d;
  logic                    drop_q, drop_d;
  logic                    ptr_inc;
  logic [C_SLOT_WIDTH-1:0] next_slot, curr_slot, prev_slot;

  gcbp_mod_ring_ptr #(
    .C_NUM_SLOTS  (C_NUM_SLOTS),
    .C_SLOT_WIDTH (C_SLOT_WIDTH)
  ) u_ring_ptr (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_inc    (ptr_inc),
    .o_next   (next_slot),
    .o_curr   (curr_slot),
    .o_prev   (prev_slot)
  );

  // A frame pulse outranks a coincident line pulse; that line is never counted.
  always_comb begin
    state_d        = state_q;
    line_cnt_d     = line_cnt_q;
    frames_valid_d = frames_valid_q;
    commit_d       = 1'b0;
    drop_d         = 1'b0;
    ptr_inc        = 1'b0;
    if (bus.i_new_frame) begin
      line_cnt_d = '0;
      state_d    = S_FILL;
      if (state_q == S_FULL && !bus.i_corr_busy) begin
        ptr_inc  = 1'b1;
        commit_d = 1'b1;
        if (frames_valid_q != 2'd2) begin
          frames_valid_d = frames_valid_q + 2'd1;
        end
      end else if (state_q != S_IDLE) begin
        drop_d = 1'b1;
      end
    end else if (bus.i_new_line && bus.i_valid_subimage_line && line_cnt_q != LINES_FULL) begin
      line_cnt_d = line_cnt_q + 1'b1;
      if (state_q == S_FILL && line_cnt_d == LINES_FULL) begin
        state_d = S_FULL;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q        <= S_IDLE;
      line_cnt_q     <= '0;
      frames_valid_q <= '0;
      commit_q       <= 1'b0;
      drop_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      line_cnt_q     <= line_cnt_d;
      frames_valid_q <= frames_valid_d;
      commit_q       <= commit_d;
      drop_q         <= drop_d;
    end
  end

  assign bus.o_next_slot    = next_slot;
  assign bus.o_curr_slot    = curr_slot;
  assign bus.o_prev_slot    = prev_slot;
  assign bus.o_write_addr   = (C_ADDR_WIDTH'(next_slot) << C_STRIDE_SHIFT) + C_ADDR_WIDTH'(line_cnt_q);
  assign bus.o_write_en     = bus.i_valid_subimage_line && (line_cnt_q != LINES_FULL);
  assign bus.o_line_cnt     = line_cnt_q;
  assign bus.o_frames_valid = frames_valid_q;
  assign bus.o_frame_commit = commit_q;
  assign bus.o_frame_drop   = drop_q;
endmodule

// File: tb/tb_gcbp_frame_ring_ctrl.sv
// Directed bench for the GCBP frame ring controller: default 3-slot instance and a 5-slot instance.
module tb_gcbp_frame_ring_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  gcbp_frame_ring_ctrl_if #(.C_SLOT_WIDTH(2), .C_ADDR_WIDTH(9), .C_CNT_WIDTH(7)) bus_a ();
  gcbp_frame_ring_ctrl_if #(.C_SLOT_WIDTH(3), .C_ADDR_WIDTH(9), .C_CNT_WIDTH(7)) bus_b ();

  gcbp_frame_ring_ctrl #(
    .C_NUM_SLOTS(3), .C_LINES_PER_SUBIMAGE(64), .C_SLOT_STRIDE(128), .C_ADDR_WIDTH(9)
  ) u_dut_a (
    .i_clk(clk), .i_resetn(resetn), .bus(bus_a)
  );

  gcbp_frame_ring_ctrl #(
    .C_NUM_SLOTS(5), .C_LINES_PER_SUBIMAGE(64), .C_SLOT_STRIDE(64), .C_ADDR_WIDTH(9)
  ) u_dut_b (
    .i_clk(clk), .i_resetn(resetn), .bus(bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_lines(input int n);
    bus_a.i_valid_subimage_line = 1'b1;
    bus_a.i_new_line = 1'b1;
    repeat (n) tick();
    bus_a.i_new_line = 1'b0;
  endtask

  task automatic a_frame(input logic busy);
    bus_a.i_new_frame = 1'b1;
    bus_a.i_corr_busy = busy;
    tick();
    bus_a.i_new_frame = 1'b0;
    bus_a.i_corr_busy = 1'b0;
  endtask

  task automatic b_lines(input int n);
    bus_b.i_valid_subimage_line = 1'b1;
    bus_b.i_new_line = 1'b1;
    repeat (n) tick();
    bus_b.i_new_line = 1'b0;
  endtask

  task automatic b_frame();
    bus_b.i_new_frame = 1'b1;
    tick();
    bus_b.i_new_frame = 1'b0;
  endtask

  task automatic a_slots(input string tag, input int nx, input int cu, input int pv);
    chk({tag, "_next"}, 32'(bus_a.o_next_slot), nx);
    chk({tag, "_curr"}, 32'(bus_a.o_curr_slot), cu);
    chk({tag, "_prev"}, 32'(bus_a.o_prev_slot), pv);
  endtask

  task automatic b_slots(input string tag, input int nx, input int cu, input int pv);
    chk({tag, "_next"}, 32'(bus_b.o_next_slot), nx);
    chk({tag, "_curr"}, 32'(bus_b.o_curr_slot), cu);
    chk({tag, "_prev"}, 32'(bus_b.o_prev_slot), pv);
  endtask

  initial begin
    bus_a.i_valid_subimage_line = 1'b0; bus_a.i_new_line = 1'b0;
    bus_a.i_new_frame = 1'b0;           bus_a.i_corr_busy = 1'b0;
    bus_b.i_valid_subimage_line = 1'b0; bus_b.i_new_line = 1'b0;
    bus_b.i_new_frame = 1'b0;           bus_b.i_corr_busy = 1'b0;

    // Reset values
    repeat (3) tick();
    a_slots("rst", 0, 2, 1);
    chk("rst_fv", 32'(bus_a.o_frames_valid), 0);
    chk("rst_cnt", 32'(bus_a.o_line_cnt), 0);
    chk("rst_commit", 32'(bus_a.o_frame_commit), 0);
    chk("rst_drop", 32'(bus_a.o_frame_drop), 0);
    chk("rst_addr", 32'(bus_a.o_write_addr), 0);
    resetn = 1'b1;
    tick();

    // First frame pulse out of IDLE: no pulses
    a_frame(1'b0);
    chk("idle_commit", 32'(bus_a.o_frame_commit), 0);
    chk("idle_drop", 32'(bus_a.o_frame_drop), 0);
    a_slots("idle", 0, 2, 1);

    // Full frame then commit
    a_lines(64);
    chk("t1_cnt", 32'(bus_a.o_line_cnt), 64);
    chk("t1_we_full", 32'(bus_a.o_write_en), 0);
    a_frame(1'b0);
    chk("t1_commit", 32'(bus_a.o_frame_commit), 1);
    chk("t1_drop", 32'(bus_a.o_frame_drop), 0);
    a_slots("t1", 1, 0, 2);
    chk("t1_fv", 32'(bus_a.o_frames_valid), 1);
    chk("t1_cnt0", 32'(bus_a.o_line_cnt), 0);
    a_lines(5);
    chk("t1_commit_1cyc", 32'(bus_a.o_frame_commit), 0);
    chk("t1_addr5", 32'(bus_a.o_write_addr), 133);
    chk("t1_we", 32'(bus_a.o_write_en), 1);

    // Short frame (40 lines) is dropped
    a_lines(35);
    chk("t3_cnt40", 32'(bus_a.o_line_cnt), 40);
    bus_a.i_valid_subimage_line = 1'b0;
    a_frame(1'b0);
    chk("t3_drop", 32'(bus_a.o_frame_drop), 1);
    chk("t3_commit", 32'(bus_a.o_frame_commit), 0);
    a_slots("t3", 1, 0, 2);
    chk("t3_cnt", 32'(bus_a.o_line_cnt), 0);
    chk("t3_addr", 32'(bus_a.o_write_addr), 128);
    chk("t3_fv", 32'(bus_a.o_frames_valid), 1);
    tick();
    chk("t3_drop_1cyc", 32'(bus_a.o_frame_drop), 0);

    // Three complete frames, each committed
    a_lines(64); a_frame(1'b0);
    a_slots("t2a", 2, 1, 0);
    chk("t2a_fv", 32'(bus_a.o_frames_valid), 2);
    a_lines(64); a_frame(1'b0);
    a_slots("t2b", 0, 2, 1);
    chk("t2b_fv_sat", 32'(bus_a.o_frames_valid), 2);
    a_lines(64); a_frame(1'b0);
    a_slots("t2c", 1, 0, 2);
    chk("t2c_commit", 32'(bus_a.o_frame_commit), 1);

    // Complete frame while correlator busy: drop, then commit
    a_lines(64); a_frame(1'b1);
    chk("t4_drop", 32'(bus_a.o_frame_drop), 1);
    chk("t4_nocommit", 32'(bus_a.o_frame_commit), 0);
    a_slots("t4", 1, 0, 2);
    a_lines(64); a_frame(1'b0);
    chk("t4_commit", 32'(bus_a.o_frame_commit), 1);
    chk("t4_nodrop", 32'(bus_a.o_frame_drop), 0);
    a_slots("t4b", 2, 1, 0);

    // 70 lines: counter saturates, extra lines not written
    a_lines(64);
    bus_a.i_new_line = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t5_we_extra", 32'(bus_a.o_write_en), 0);
      chk("t5_addr_cap", 32'(bus_a.o_write_addr), 320);
      tick();
    end
    bus_a.i_new_line = 1'b0;
    chk("t5_cnt_sat", 32'(bus_a.o_line_cnt), 64);

    // Coincident frame and line pulses: frame wins
    bus_a.i_new_line = 1'b1;
    a_frame(1'b0);
    bus_a.i_new_line = 1'b0;
    chk("sim_commit", 32'(bus_a.o_frame_commit), 1);
    chk("sim_drop", 32'(bus_a.o_frame_drop), 0);
    chk("sim_cnt", 32'(bus_a.o_line_cnt), 0);
    a_slots("sim", 0, 2, 1);
    bus_a.i_valid_subimage_line = 1'b0;

    // Five-slot instance: wrap after 5 commits
    b_frame();
    for (int k = 1; k <= 5; k++) begin
      b_lines(64);
      b_frame();
      chk("t6_commit", 32'(bus_b.o_frame_commit), 1);
      chk("t6_next", 32'(bus_b.o_next_slot), k % 5);
      if (k == 1) begin
        b_slots("t6_first", 1, 0, 4);
        chk("t6_addr_base", 32'(bus_b.o_write_addr), 64);
      end
    end
    b_slots("t6_wrap", 0, 4, 3);
    chk("t6_fv", 32'(bus_b.o_frames_valid), 2);
    b_lines(64); b_frame();
    b_lines(10);
    chk("t6_cnt10", 32'(bus_b.o_line_cnt), 10);
    chk("t6_addr", 32'(bus_b.o_write_addr), 74);

    // Asynchronous reset mid-cycle, no clock edge
    bus_b.i_new_line = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    b_slots("arst", 0, 4, 3);
    chk("arst_cnt", 32'(bus_b.o_line_cnt), 0);
    chk("arst_fv", 32'(bus_b.o_frames_valid), 0);
    chk("arst_addr", 32'(bus_b.o_write_addr), 0);
    chk("arst_drop", 32'(bus_b.o_frame_drop), 0);
    chk("arst_a_fv", 32'(bus_a.o_frames_valid), 0);
    bus_b.i_new_line = 1'b0;
    bus_b.i_valid_subimage_line = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
